// File: rtl/adder_arbiter_pkg.sv
// Shared widths and FSM state type for the adder arbiter slice.
package adder_arbiter_pkg;
  localparam int OPND_W = 5;
  localparam int SUM_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder.sv
// Shared unsigned adder: zero-extends both operands so the sum never truncates.
module adder
  import adder_arbiter_pkg::*;
(
  input  logic [OPND_W-1:0] i_in1,
  input  logic [OPND_W-1:0] i_in2,
  output logic [SUM_W-1:0]  o_sum
);
  assign o_sum = SUM_W'(i_in1) + SUM_W'(i_in2);
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_en,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_idx,
  output logic           o_gnt_valid
);
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  // Scan from farthest to nearest so the nearest valid index wins.
  always_comb begin
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_en && i_req[wrap_idx(i_ptr, k)]) begin
        o_gnt_idx   = wrap_idx(i_ptr, k);
        o_gnt_valid = 1'b1;
      end
    end
    if (o_gnt_valid) o_gnt[o_gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NUM_REQ requesters with a tagged response.
// Define ADDER_ARBITER_BACK2BACK_EN to re-arbitrate on the response handshake cycle.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [OPND_W*NUM_REQ-1:0] req_in1,
  input  logic [OPND_W*NUM_REQ-1:0] req_in2,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [SUM_W-1:0]          resp_sum,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      resp_ready,
  output logic                      busy
);
  state_t              r_state;
  state_t              w_state_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gid;
  logic [ID_W-1:0]     r_id;
  logic [OPND_W-1:0]   r_op1;
  logic [OPND_W-1:0]   r_op2;
  logic [SUM_W-1:0]    r_sum;
  logic                r_valid;
  logic [SUM_W-1:0]    w_sum;
  logic                w_arb_en;
  logic                w_resp_hs;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_gnt_valid;

  assign w_resp_hs = (r_state == DONE) && resp_ready;

`ifdef ADDER_ARBITER_BACK2BACK_EN
  assign w_arb_en = (r_state == IDLE) || w_resp_hs;
`else
  assign w_arb_en = (r_state == IDLE);
`endif

  rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .i_en        (w_arb_en),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  adder u_adder (
    .i_in1 (r_op1),
    .i_in2 (r_op2),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_next = EXEC;
      EXEC:    w_state_next = DONE;
      DONE:    if (w_resp_hs) w_state_next = w_gnt_valid ? EXEC : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = w_gnt;
    busy      = (r_state != IDLE);
  end

  // Operands and the owner id are captured only on the grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_gid   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_sum   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_gnt_valid) begin
        r_op1 <= req_in1[w_gnt_idx*OPND_W +: OPND_W];
        r_op2 <= req_in2[w_gnt_idx*OPND_W +: OPND_W];
        r_gid <= w_gnt_idx;
        r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (r_state == EXEC) begin
        r_sum   <= w_sum;
        r_id    <= r_gid;
        r_valid <= 1'b1;
      end else if (w_resp_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign resp_valid = r_valid;
  assign resp_sum   = r_sum;
  assign resp_id    = r_id;
endmodule
